// File: rtl/divisor_reloj_pkg.sv
// -----------------------------------------------------------------------------
// divisor_reloj_pkg
// Shared constants for the programmable clock divider: system clock frequency,
// default counter width, the reset divisor, and a helper that converts a wanted
// output frequency into the half-period terminal value the divider expects.
// No ports (package).
// -----------------------------------------------------------------------------
package divisor_reloj_pkg;

    localparam int unsigned CLK_HZ            = 32'd100_000_000;
    localparam int          DIV_WIDTH_DEFAULT = 32'sd16;
    localparam int          DIV_RESET_DEFAULT = 32'sd4999;

    // Half-period terminal value giving an output of f_hz on clk_dividido.
    function automatic int unsigned div_for_hz(input int unsigned f_hz);
        return (CLK_HZ / (32'd2 * f_hz)) - 32'd1;
    endfunction

endpackage

// File: rtl/divisor_reloj_prog_contador_terminal.sv
// -----------------------------------------------------------------------------
// contador_terminal
// WIDTH-bit up counter that wraps to zero when it reaches a programmable limit.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous reset, active-high (counter -> 0)
//   en       in   count enable; low holds the count
//   clr      in   synchronous clear, wins over counting
//   limit    in   terminal value; the count wraps after reaching it
//   at_term  out  high while the count equals limit
// -----------------------------------------------------------------------------
module contador_terminal
    import divisor_reloj_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] limit,
    output logic             at_term
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next-count selection: clear, wrap at the limit, increment, or hold.
    always_comb begin
        at_term = (count_q == limit);
        count_d = count_q;
        if (clr) begin
            count_d = {WIDTH{1'b0}};
        end else if (en) begin
            if (at_term) begin
                count_d = {WIDTH{1'b0}};
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= {WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/divisor_reloj_prog.sv
// -----------------------------------------------------------------------------
// divisor_reloj_prog
// Runtime-programmable clock divider. Produces a 50% duty divided clock and a
// one-cycle tick from the system clock. New divisors are captured in a shadow
// register and only become active at a period boundary (or immediately while
// counting is frozen), so clk_dividido never glitches.
//
// Ports:
//   clk           in   system clock (100 MHz)
//   rst           in   synchronous reset, active-high
//   en            in   count enable; low freezes counter and outputs
//   div_in        in   requested half-period terminal value
//   div_load      in   load request, div_in captured on every edge it is high
//   sync_in       in   phase reset (only with DIVISOR_RELOJ_SYNC_EN defined)
//   div_ack       out  one-cycle pulse when the shadow value becomes active
//   div_actual    out  currently active terminal value
//   clk_dividido  out  divided clock, f_clk/(2*(div_actual+1))
//   tick          out  one-cycle pulse at each terminal count
//
// Optional feature macro: DIVISOR_RELOJ_SYNC_EN adds sync_in, which restarts
// the period (counter, clk_dividido and tick to zero) to phase-align dividers.
// -----------------------------------------------------------------------------
module divisor_reloj_prog
    import divisor_reloj_pkg::*;
#(
    parameter int WIDTH     = DIV_WIDTH_DEFAULT,
    parameter int DIV_RESET = DIV_RESET_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
`ifdef DIVISOR_RELOJ_SYNC_EN
    input  logic             sync_in,
`endif
    output logic             div_ack,
    output logic [WIDTH-1:0] div_actual,
    output logic             clk_dividido,
    output logic             tick
);

    logic [WIDTH-1:0] div_actual_q, div_actual_d;
    logic [WIDTH-1:0] shadow_q,     shadow_d;
    logic             pending_q,    pending_d;
    logic             clk_div_q,    clk_div_d;
    logic             tick_q,       tick_d;
    logic             ack_q,        ack_d;

    logic             at_term_s;
    logic             term_s;
    logic             apply_s;
    logic             clr_s;

    contador_terminal #(
        .WIDTH (WIDTH)
    ) u_contador (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .clr     (clr_s),
        .limit   (div_actual_q),
        .at_term (at_term_s)
    );

    // Shadow handshake, divisor switch-over and output toggle.
    always_comb begin
        term_s       = en && at_term_s;
        div_actual_d = div_actual_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        clk_div_d    = clk_div_q;
        tick_d       = 1'b0;
        ack_d        = 1'b0;
        clr_s        = 1'b0;
        apply_s      = 1'b0;

        // A load on this edge always wins: the freshly captured value waits
        // for the next boundary, superseding any older shadow value.
        if (div_load) begin
            shadow_d  = div_in;
            pending_d = 1'b1;
        end else begin
`ifdef DIVISOR_RELOJ_SYNC_EN
            apply_s = pending_q && (term_s || !en || sync_in);
`else
            apply_s = pending_q && (term_s || !en);
`endif
        end

        if (term_s) begin
            clk_div_d = ~clk_div_q;
            tick_d    = 1'b1;
        end else begin
            clk_div_d = clk_div_q;
            tick_d    = 1'b0;
        end

        if (apply_s) begin
            div_actual_d = shadow_q;
            pending_d    = 1'b0;
            ack_d        = 1'b1;
            // While frozen, the new period starts from zero; while counting the
            // counter is already wrapping at the terminal edge.
            clr_s        = !en;
        end else begin
            div_actual_d = div_actual_q;
        end

`ifdef DIVISOR_RELOJ_SYNC_EN
        if (sync_in) begin
            clr_s     = 1'b1;
            clk_div_d = 1'b0;
            tick_d    = 1'b0;
        end else begin
            clk_div_d = clk_div_d;
        end
`endif
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_actual_q <= WIDTH'(DIV_RESET);
            shadow_q     <= {WIDTH{1'b0}};
            pending_q    <= 1'b0;
            clk_div_q    <= 1'b0;
            tick_q       <= 1'b0;
            ack_q        <= 1'b0;
        end else begin
            div_actual_q <= div_actual_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            clk_div_q    <= clk_div_d;
            tick_q       <= tick_d;
            ack_q        <= ack_d;
        end
    end

    assign div_actual   = div_actual_q;
    assign clk_dividido = clk_div_q;
    assign tick         = tick_q;
    assign div_ack      = ack_q;

endmodule
